// File: rtl/simplez_pkg.sv
// Shared SIMPLEZ constants and types: word/address widths, arbiter state,
// master indices and the LED peripheral address.
package simplez_pkg;

  localparam int DATAW = 12;
  localparam int ADDRW = 9;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  localparam logic [ADDRW-1:0] LED_ADDR = 9'o100;

endpackage

// File: rtl/simplez_rr_pick.sv
// Two-way round-robin picker: on conflict the master that did not win last
// time is granted. Purely combinational; the caller owns the last register.
module simplez_rr_pick
  import simplez_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == M_DBG) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/simplez_mem_arbiter.sv
// Shares the single-port SIMPLEZ memory between the CPU and a debug/loader
// master; the loader can lock the memory and freeze the CPU sequencer.
//
// state | meaning
// ARB   | round-robin between CPU and debug master
// LOCK  | debug master owns memory, CPU sequencer held
module simplez_mem_arbiter
  import simplez_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [ADDRW-1:0] c_addr,
  input  logic [DATAW-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_rvalid,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [ADDRW-1:0] d_addr,
  input  logic [DATAW-1:0] d_wdata,
  input  logic             d_lock,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DATAW-1:0] rdata,
  output logic             cpu_hold,
  output logic [ADDRW-1:0] m_addr,
  output logic             m_we,
  output logic [DATAW-1:0] m_wdata,
  input  logic [DATAW-1:0] m_rdata
);

  arb_state_t state, state_nxt;
  logic       last;
  logic       c_pend, d_pend;
  logic [1:0] req_eff;
  logic [1:0] pick_gnt;

  // In LOCK the CPU request is masked so only the debug master can win.
  assign req_eff = {d_req, c_req & (state == ARB)};

  simplez_rr_pick u_pick (
    .req  (req_eff),
    .last (last),
    .gnt  (pick_gnt)
  );

  always_ff @(negedge clk) begin
    if (!rstn) begin
      state  <= ARB;
      last   <= M_DBG;
      c_pend <= 1'b0;
      d_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (c_gnt)
        last <= M_CPU;
      else if (d_gnt)
        last <= M_DBG;
      c_pend <= c_gnt & ~c_we;
      d_pend <= d_gnt & ~d_we;
    end
  end

  always_comb begin
    state_nxt = state;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    m_addr    = c_addr;
    m_wdata   = c_wdata;
    m_we      = 1'b0;

    // Outputs are forced quiet during reset so nothing reaches memory.
    if (rstn) begin
      c_gnt = pick_gnt[0];
      d_gnt = pick_gnt[1];
    end

    if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_we    = d_we;
    end else if (c_gnt) begin
      m_we    = c_we;
    end

    case (state)
      ARB:     if (d_gnt && d_lock) state_nxt = LOCK;
      LOCK:    if (!d_lock)         state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  assign c_rvalid = c_pend & rstn;
  assign d_rvalid = d_pend & rstn;
  assign cpu_hold = (state == LOCK) & rstn;
  assign rdata    = m_rdata;

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Directed bench for simplez_mem_arbiter with a synchronous 512x12 memory model.
module tb_simplez_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [8:0]  c_addr, d_addr;
  logic [11:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, cpu_hold, m_we;
  logic [11:0] rdata, m_wdata;
  logic [11:0] m_rdata = 12'o0;
  logic [8:0]  m_addr;

  int checks = 0;
  int failures = 0;

  logic [11:0] mem [512];
  bit          written [512];

  simplez_mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .cpu_hold(cpu_hold),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] preload(input logic [8:0] a);
    case (a)
      9'o010:  return 12'o1234;
      9'o020:  return 12'o1111;
      9'o030:  return 12'o2222;
      9'o040:  return 12'o4321;
      default: return 12'o0000;
    endcase
  endfunction

  // Memory shares the arbiter's falling edge; read data appears one cycle later.
  always @(negedge clk) begin
    if (m_we) begin
      mem[m_addr]     <= m_wdata;
      written[m_addr] <= 1'b1;
    end
    m_rdata <= written[m_addr] ? mem[m_addr] : preload(m_addr);
  end

  // Cycle framing: inputs change at negedge+1, outputs are checked at posedge.
  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rstn = 0;
    next_cycle();
    rstn = 1;
  endtask

  task automatic test_reset;
    rstn = 0;
    c_req = 1; c_we = 1; d_req = 1; d_we = 1; d_lock = 1;
    @(posedge clk);
    checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt c=%b d=%b want 0 0", c_gnt, d_gnt); end
    checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL rst_mwe got %b want 0", m_we); end
    checks++; if (cpu_hold !== 1'b0 || c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_out hold=%b crv=%b drv=%b want 0 0 0", cpu_hold, c_rvalid, d_rvalid); end
    next_cycle();
    rstn = 1;
    idle_inputs();
  endtask

  task automatic test_cpu_read;
    do_reset();
    c_req = 1; c_addr = 9'o010;
    @(posedge clk);
    checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL rd_gnt c=%b d=%b want 1 0", c_gnt, d_gnt); end
    checks++; if (m_addr !== 9'o010 || m_we !== 1'b0) begin failures++; $display("FAIL rd_maddr addr=%o we=%b want 010 0", m_addr, m_we); end
    next_cycle();
    c_req = 0;
    @(posedge clk);
    checks++; if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid c=%b d=%b want 1 0", c_rvalid, d_rvalid); end
    checks++; if (rdata !== 12'o1234) begin failures++; $display("FAIL rd_data got %o want 1234", rdata); end
    checks++; if (c_gnt !== 1'b0) begin failures++; $display("FAIL rd_nogrant got %b want 0", c_gnt); end
    next_cycle();
  endtask

  task automatic test_alternate;
    logic exp_c;
    do_reset();
    c_req = 1; c_addr = 9'o020; d_req = 1; d_addr = 9'o030;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin c_req = 0; d_req = 0; end
      @(posedge clk);
      exp_c = (i % 2 == 0);
      if (i < 6) begin
        checks++; if (c_gnt !== exp_c || d_gnt !== !exp_c) begin failures++; $display("FAIL alt_gnt[%0d] c=%b d=%b want %b %b", i, c_gnt, d_gnt, exp_c, !exp_c); end
        checks++; if (m_addr !== (exp_c ? 9'o020 : 9'o030)) begin failures++; $display("FAIL alt_addr[%0d] got %o", i, m_addr); end
      end
      if (i > 0) begin
        // Read issued last cycle went to the opposite master of this cycle's pattern.
        checks++; if (c_rvalid !== !exp_c || d_rvalid !== exp_c) begin failures++; $display("FAIL alt_rv[%0d] c=%b d=%b want %b %b", i, c_rvalid, d_rvalid, !exp_c, exp_c); end
        checks++; if (rdata !== (exp_c ? 12'o2222 : 12'o1111)) begin failures++; $display("FAIL alt_data[%0d] got %o", i, rdata); end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock;
    // Single CPU read first so the following conflict goes to the debug master.
    c_req = 1; c_addr = 9'o040;
    @(posedge clk);
    checks++; if (c_gnt !== 1'b1) begin failures++; $display("FAIL lk_pre got %b want 1", c_gnt); end
    next_cycle();
    d_req = 1; d_we = 1; d_lock = 1;
    for (int i = 0; i < 4; i++) begin
      d_addr = 9'(i); d_wdata = 12'o7000 + 12'(i);
      @(posedge clk);
      checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin failures++; $display("FAIL lk_gnt[%0d] d=%b c=%b want 1 0", i, d_gnt, c_gnt); end
      checks++; if (m_we !== 1'b1 || m_addr !== 9'(i) || m_wdata !== 12'o7000 + 12'(i)) begin failures++; $display("FAIL lk_mem[%0d] we=%b addr=%o wd=%o", i, m_we, m_addr, m_wdata); end
      checks++; if (cpu_hold !== (i > 0)) begin failures++; $display("FAIL lk_hold[%0d] got %b want %b", i, cpu_hold, i > 0); end
      if (i == 0) begin
        checks++; if (c_rvalid !== 1'b1 || rdata !== 12'o4321) begin failures++; $display("FAIL lk_crv got %b/%o want 1/4321", c_rvalid, rdata); end
      end
      next_cycle();
    end
    d_req = 0; d_we = 0; d_lock = 0;
    @(posedge clk);
    checks++; if (cpu_hold !== 1'b1 || c_gnt !== 1'b0) begin failures++; $display("FAIL lk_release hold=%b cg=%b want 1 0", cpu_hold, c_gnt); end
    next_cycle();
    @(posedge clk);
    checks++; if (cpu_hold !== 1'b0 || c_gnt !== 1'b1) begin failures++; $display("FAIL lk_exit hold=%b cg=%b want 0 1", cpu_hold, c_gnt); end
    next_cycle();
    c_req = 0;
    @(posedge clk);
    checks++; if (c_rvalid !== 1'b1 || rdata !== 12'o4321) begin failures++; $display("FAIL lk_post_rd got %b/%o want 1/4321", c_rvalid, rdata); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (!written[i] || mem[i] !== 12'o7000 + 12'(i)) begin failures++; $display("FAIL lk_store[%0d] got %o want %o", i, mem[i], 12'o7000 + 12'(i)); end
    end
    next_cycle();
  endtask

  task automatic test_cpu_write;
    c_req = 1; c_we = 1; c_addr = 9'o100; c_wdata = 12'o0005;
    @(posedge clk);
    checks++; if (c_gnt !== 1'b1 || m_we !== 1'b1) begin failures++; $display("FAIL wr_strobe gnt=%b we=%b want 1 1", c_gnt, m_we); end
    checks++; if (m_addr !== 9'o100 || m_wdata !== 12'o0005) begin failures++; $display("FAIL wr_bus addr=%o wd=%o want 100 0005", m_addr, m_wdata); end
    next_cycle();
    idle_inputs();
    @(posedge clk);
    checks++; if (m_we !== 1'b0 || c_rvalid !== 1'b0) begin failures++; $display("FAIL wr_after we=%b crv=%b want 0 0", m_we, c_rvalid); end
    checks++; if (mem[9'o100] !== 12'o0005) begin failures++; $display("FAIL wr_store got %o want 0005", mem[9'o100]); end
    next_cycle();
  endtask

  task automatic test_reset_in_lock;
    d_req = 1; d_lock = 1; d_addr = 9'o030;
    @(posedge clk);
    checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL rl_enter got %b want 1", d_gnt); end
    next_cycle();
    @(posedge clk);
    checks++; if (cpu_hold !== 1'b1 || d_gnt !== 1'b1 || d_rvalid !== 1'b1) begin failures++; $display("FAIL rl_locked hold=%b dg=%b drv=%b want 1 1 1", cpu_hold, d_gnt, d_rvalid); end
    next_cycle();
    rstn = 0;
    @(posedge clk);
    checks++; if (d_gnt !== 1'b0 || d_rvalid !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL rl_inrst dg=%b drv=%b hold=%b want 0 0 0", d_gnt, d_rvalid, cpu_hold); end
    next_cycle();
    rstn = 1; d_lock = 0; c_req = 1; c_addr = 9'o010;
    @(posedge clk);
    checks++; if (cpu_hold !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL rl_after hold=%b drv=%b want 0 0", cpu_hold, d_rvalid); end
    checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL rl_conflict c=%b d=%b want 1 0", c_gnt, d_gnt); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_idle;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      checks++; if (m_we !== 1'b0 || c_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++; $display("FAIL idle[%0d] we=%b c=%b d=%b want 0 0 0", i, m_we, c_gnt, d_gnt); end
      next_cycle();
    end
    // Last winner before idling was the CPU, so the debug master wins now.
    c_req = 1; d_req = 1; c_addr = 9'o020; d_addr = 9'o030;
    @(posedge clk);
    checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin failures++; $display("FAIL idle_rr1 c=%b d=%b want 0 1", c_gnt, d_gnt); end
    next_cycle();
    @(posedge clk);
    checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL idle_rr2 c=%b d=%b want 1 0", c_gnt, d_gnt); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    next_cycle();
    test_reset();
    test_cpu_read();
    test_alternate();
    test_lock();
    test_cpu_write();
    test_reset_in_lock();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
